// File: rtl/io_irq_vec16.sv
// Interrupt vectoring stage: latches rising edges of masked IRQ lines, presents the
// lowest-index pending line to the core over req/ack and holds it in service until EOI.
module io_irq_vec16 #(
    parameter logic [15:0] CAddrBase = 16'h0000,
    parameter int unsigned CIrqCnt   = 16
) (
    input  logic               AClkH,
    input  logic               AResetHN,
    input  logic               AClkHEn,
    input  logic [15:0]        AIoAddr,
    output logic [63:0]        AIoMiso,
    input  logic [63:0]        AIoMosi,
    input  logic [3:0]         AIoWrSize,
    input  logic [3:0]         AIoRdSize,
    output logic               AIoAddrAck,
    output logic               AIoAddrErr,
    input  logic [CIrqCnt-1:0] AIrqI,
    output logic               AIrqReq,
    output logic [3:0]         AIrqVec,
    input  logic               AIrqAck,
    output logic [7:0]         ATest
);

    localparam logic [3:0] SzW = 4'b0010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StServ = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CIrqCnt-1:0] prev_q, pend_q, pend_d, set, clr;
    logic [3:0]         vec_q, vec_d, serv_q, serv_d, hi;
    logic [15:0]        pend_ext;
    logic               any, hit0, hit2, hit, wr_any, rd_any, size_err;
    logic               wr_ok, rd_ok, w1c, eoi, ack_take;
    logic               unused_mosi;

    assign unused_mosi = ^AIoMosi[63:CIrqCnt];

    // IO decode: only word accesses at +0/+2 have any effect.
    assign hit0       = (AIoAddr == CAddrBase);
    assign hit2       = (AIoAddr == (CAddrBase + 16'd2));
    assign hit        = hit0 | hit2;
    assign wr_any     = |AIoWrSize;
    assign rd_any     = |AIoRdSize;
    assign size_err   = (wr_any && (AIoWrSize != SzW)) || (rd_any && (AIoRdSize != SzW));
    assign AIoAddrAck = hit && (wr_any || rd_any);
    assign AIoAddrErr = hit && size_err;
    assign wr_ok      = hit && (AIoWrSize == SzW) && !size_err;
    assign rd_ok      = hit && (AIoRdSize == SzW) && !size_err;
    assign w1c        = wr_ok && hit0;
    assign eoi        = wr_ok && hit2;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        hi = '0;
        for (int i = int'(CIrqCnt) - 1; i >= 0; i--) begin
            if (pend_q[i]) hi = 4'(i);
        end
    end
    assign any = |pend_q;

    assign ack_take = (state_q == StReq) && AIrqAck;
    assign set      = AIrqI & ~prev_q;

    always_comb begin
        clr = w1c ? AIoMosi[CIrqCnt-1:0] : '0;
        for (int i = 0; i < int'(CIrqCnt); i++) begin
            if (ack_take && (vec_q == 4'(i))) clr[i] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle edge survives a W1C.
    assign pend_d = (pend_q & ~clr) | set;

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            state_q <= StIdle;
            prev_q  <= '0;
            pend_q  <= '0;
            vec_q   <= '0;
            serv_q  <= '0;
        end else if (AClkHEn) begin
            state_q <= state_d;
            prev_q  <= AIrqI;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            serv_q  <= serv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (any) state_d = StReq;
            StReq: begin
                if (AIrqAck)   state_d = StServ;
                else if (!any) state_d = StIdle;
            end
            StServ: if (eoi) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vec_d  = vec_q;
        serv_d = serv_q;
        if ((state_q == StIdle) && any) vec_d = hi;
        if (state_q == StReq) begin
            if (AIrqAck)  serv_d = vec_q;
            else if (any) vec_d  = hi;
        end
    end

    always_comb begin
        pend_ext                = '0;
        pend_ext[CIrqCnt-1:0]   = pend_q;
        AIoMiso                 = '0;
        if (rd_ok && hit0) AIoMiso[15:0] = pend_ext;
        if (rd_ok && hit2) AIoMiso[15:0] = {state_q, 6'h0, 4'h0, serv_q};
        AIrqReq = (state_q == StReq);
        AIrqVec = vec_q;
        ATest   = {state_q, AIrqReq, 1'b0, AIrqVec};
    end

endmodule

// File: tb/tb_io_irq_vec16.sv
// Bench for io_irq_vec16: directed vector table, hand sequences, then random traffic
// against a cycle-level reference model.
module tb_io_irq_vec16;

    localparam logic [15:0] A0 = 16'h0040;
    localparam logic [15:0] A2 = 16'h0042;
    localparam logic [3:0]  SW = 4'b0010;
    localparam logic [3:0]  SB = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n, en, ack;
    logic [15:0] irq, addr;
    logic [3:0]  wr, rd, vec;
    logic [63:0] mosi, miso;
    logic        aack, aerr, req;
    logic [7:0]  test;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_irq_vec16 #(.CAddrBase(A0), .CIrqCnt(16)) dut (
        .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .AIoAddr(addr), .AIoMiso(miso),
        .AIoMosi(mosi), .AIoWrSize(wr), .AIoRdSize(rd), .AIoAddrAck(aack),
        .AIoAddrErr(aerr), .AIrqI(irq), .AIrqReq(req), .AIrqVec(vec), .AIrqAck(ack),
        .ATest(test)
    );

    // Reference model state.
    int          m_state;
    logic [15:0] m_pend, m_prev;
    logic [3:0]  m_vec, m_serv;

    function automatic logic m_err();
        return (addr == A0 || addr == A2) && ((wr != 0 && wr != SW) || (rd != 0 && rd != SW));
    endfunction

    function automatic logic m_aack();
        return (addr == A0 || addr == A2) && (wr != 0 || rd != 0);
    endfunction

    function automatic logic [63:0] m_miso();
        logic [63:0] r;
        r = 64'h0;
        if (rd == SW && !m_err()) begin
            if (addr == A0) r = {48'h0, m_pend};
            if (addr == A2) r = {48'h0, m_state[1:0], 10'h0, m_serv};
        end
        return r;
    endfunction

    task automatic m_step();
        logic [15:0] np;
        int          low;
        logic        wok;
        if (!rst_n) begin
            m_state = 0; m_pend = 0; m_prev = 0; m_vec = 0; m_serv = 0;
        end else if (en) begin
            low = -1;
            for (int i = 0; i < 16; i++) if (m_pend[i] && low < 0) low = i;
            wok = (wr == SW) && !m_err();
            np = m_pend;
            if (wok && addr == A0) np = np & ~mosi[15:0];
            case (m_state)
                0: if (low >= 0) begin m_state = 1; m_vec = 4'(low); end
                1: begin
                    if (ack) begin
                        m_serv = m_vec; np[m_vec] = 1'b0; m_state = 2;
                    end else if (low >= 0) m_vec = 4'(low);
                    else m_state = 0;
                end
                default: if (wok && addr == A2) m_state = 0;
            endcase
            m_pend = np | (irq & ~m_prev);
            m_prev = irq;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [15:0] i, input logic a,
                         input logic [15:0] ad, input logic [3:0] w, input logic [3:0] rr,
                         input logic [63:0] mo);
        @(negedge clk);
        rst_n = r; en = e; irq = i; ack = a; addr = ad; wr = w; rd = rr; mosi = mo;
        #1;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
    endtask

    typedef struct {
        logic        rst_n;
        logic [15:0] irq;
        logic        ack;
        logic [15:0] addr;
        logic [3:0]  wr;
        logic [3:0]  rd;
        logic [15:0] mosi;
        logic        e_req;
        logic [3:0]  e_vec;
        logic [63:0] e_miso;
        logic        e_aack;
        logic        e_aerr;
    } row_t;

    function automatic row_t mk(logic r, logic [15:0] i, logic a, logic [15:0] ad,
                                logic [3:0] w, logic [3:0] rr, logic [15:0] mo, logic eq,
                                logic [3:0] ev, logic [63:0] em, logic ea, logic ee);
        row_t t;
        t.rst_n = r; t.irq = i; t.ack = a; t.addr = ad; t.wr = w; t.rd = rr; t.mosi = mo;
        t.e_req = eq; t.e_vec = ev; t.e_miso = em; t.e_aack = ea; t.e_aerr = ee;
        return t;
    endfunction

    row_t tbl[21];

    initial begin
        tbl[0]  = mk(1, 16'h0020, 0, 16'h0, 0,  0,  0,       0, 0, 64'h0,    0, 0);
        tbl[1]  = mk(1, 16'h0000, 0, 16'h0, 0,  0,  0,       0, 0, 64'h0,    0, 0);
        tbl[2]  = mk(1, 16'h0000, 0, A0,    0,  SW, 0,       1, 5, 64'h20,   1, 0);
        tbl[3]  = mk(1, 16'h0000, 0, A2,    0,  SW, 0,       1, 5, 64'h4000, 1, 0);
        tbl[4]  = mk(1, 16'h0000, 0, A0,    0,  SB, 0,       1, 5, 64'h0,    1, 1);
        tbl[5]  = mk(1, 16'h0000, 1, 16'h0, 0,  0,  0,       1, 5, 64'h0,    0, 0);
        tbl[6]  = mk(1, 16'h0008, 0, A2,    0,  SW, 0,       0, 0, 64'h8005, 1, 0);
        tbl[7]  = mk(1, 16'h0000, 0, 16'h0, 0,  0,  0,       0, 0, 64'h0,    0, 0);
        tbl[8]  = mk(1, 16'h0000, 0, A2,    SW, 0,  0,       0, 0, 64'h0,    1, 0);
        tbl[9]  = mk(1, 16'h0000, 0, 16'h0, 0,  0,  0,       0, 0, 64'h0,    0, 0);
        tbl[10] = mk(1, 16'h0000, 0, A0,    0,  SW, 0,       1, 3, 64'h8,    1, 0);
        tbl[11] = mk(1, 16'h0000, 0, A0,    SW, 0,  16'h0008, 1, 3, 64'h0,   1, 0);
        tbl[12] = mk(1, 16'h0000, 0, 16'h0, 0,  0,  0,       1, 3, 64'h0,    0, 0);
        tbl[13] = mk(1, 16'h0000, 0, A0,    0,  SW, 0,       0, 0, 64'h0,    1, 0);
        tbl[14] = mk(1, 16'h0010, 0, 16'h0, 0,  0,  0,       0, 0, 64'h0,    0, 0);
        tbl[15] = mk(1, 16'h0000, 0, 16'h0, 0,  0,  0,       0, 0, 64'h0,    0, 0);
        tbl[16] = mk(1, 16'h0010, 0, A0,    SW, 0,  16'h0010, 1, 4, 64'h0,   1, 0);
        tbl[17] = mk(1, 16'h0000, 0, A0,    0,  SW, 0,       1, 4, 64'h10,   1, 0);
        tbl[18] = mk(0, 16'h0000, 1, 16'h0, 0,  0,  0,       1, 4, 64'h0,    0, 0);
        tbl[19] = mk(1, 16'h0000, 1, A2,    0,  SW, 0,       0, 0, 64'h0,    1, 0);
        tbl[20] = mk(1, 16'h0000, 0, A0,    0,  SW, 0,       0, 0, 64'h0,    1, 0);

        // Power-up reset, unchecked.
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst_n, 1, tbl[i].irq, tbl[i].ack, tbl[i].addr, tbl[i].wr, tbl[i].rd,
                  {48'h0, tbl[i].mosi});
            chk($sformatf("row%0d req", i), 64'(req), 64'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("row%0d vec", i), 64'(vec), 64'(tbl[i].e_vec));
            chk($sformatf("row%0d miso", i), miso, tbl[i].e_miso);
            chk($sformatf("row%0d addr_ack", i), 64'(aack), 64'(tbl[i].e_aack));
            chk($sformatf("row%0d addr_err", i), 64'(aerr), 64'(tbl[i].e_aerr));
            tick();
        end

        // Higher-priority arrival re-targets the vector before ack.
        drive(1, 1, 16'h0200, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'h0000, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'h0004, 0, 0, 0, 0, 0);
        chk("retarget req", 64'(req), 64'd1);
        chk("retarget vec9", 64'(vec), 64'd9); tick();
        drive(1, 1, 16'h0000, 0, 0, 0, 0, 0);
        chk("retarget vec9 hold", 64'(vec), 64'd9); tick();
        drive(1, 1, 16'h0000, 1, 0, 0, 0, 0);
        chk("retarget vec2", 64'(vec), 64'd2); tick();
        drive(1, 1, 16'h0000, 0, A2, 0, SW, 0);
        chk("serv req", 64'(req), 64'd0);
        chk("serv status", miso, 64'h8002); tick();
        drive(1, 1, 16'h0000, 0, A0, 0, SW, 0);
        chk("serv pend", miso, 64'h0200); tick();

        // Clock enable: a pulse seen only while disabled is lost, a held line is caught.
        drive(1, 0, 16'h0080, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 16'h0000, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'h0000, 0, A0, 0, SW, 0);
        chk("en pulse lost", miso, 64'h0200); tick();
        drive(1, 0, 16'h0080, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'h0080, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 16'h0080, 0, A0, 0, SW, 0);
        chk("en level caught", miso, 64'h0280); tick();

        for (int c = 0; c < 600; c++) begin
            logic [15:0] ri, ra;
            logic [3:0]  rw, rr;
            int          op;
            ri = ($urandom_range(0, 1) == 0) ? irq : 16'($urandom & $urandom & $urandom);
            case ($urandom_range(0, 4))
                0: ra = A0;
                1: ra = A2;
                2: ra = A0 + 16'd1;
                3: ra = A0 + 16'd4;
                default: ra = 16'($urandom);
            endcase
            rw = 0; rr = 0;
            op = $urandom_range(0, 4);
            if (op == 1 || op == 3) rw = ($urandom_range(0, 3) != 0) ? SW : 4'($urandom);
            if (op == 2 || op == 3) rr = ($urandom_range(0, 3) != 0) ? SW : 4'($urandom);
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0, ri,
                  $urandom_range(0, 2) == 0, ra, rw, rr, {$urandom, $urandom});
            chk($sformatf("rnd%0d req", c), 64'(req), 64'(m_state == 1));
            if (m_state == 1) chk($sformatf("rnd%0d vec", c), 64'(vec), 64'(m_vec));
            chk($sformatf("rnd%0d miso", c), miso, m_miso());
            chk($sformatf("rnd%0d addr_ack", c), 64'(aack), 64'(m_aack()));
            chk($sformatf("rnd%0d addr_err", c), 64'(aerr), 64'(m_err()));
            chk($sformatf("rnd%0d test", c), 64'(test[7:4]),
                64'({m_state[1:0], m_state == 1, 1'b0}));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
